// File: rtl/div_sequencer.sv
// ---------------------------------------------------------------------------
// div_sequencer
//
// Control and operand-preparation stage in front of the iterative unsigned
// divider in the RV32I execute stage. It handles M-extension
// DIV/DIVU/REM/REMU requests as follows:
//   - Signed operands are turned into unsigned magnitudes for the divider.
//   - Divide-by-zero and signed overflow are resolved locally, without the
//     divider.
//   - Each divider request is a one-cycle strobe. The sequencer then waits for
//     the divider's done strobe, applies sign correction, and presents one
//     registered result.
//
// Ports
//   Clk, Rst        clock (rising edge), synchronous active-high reset
//   Start           request strobe from the execute stage
//   Op              funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   Op_a, Op_b      dividend (rs1), divisor (rs2)
//   Flush           pipeline flush, kills the current operation
//   Busy            stall request to the hazard unit
//   Result          final quotient or remainder (held until the next result)
//   Result_valid    one-cycle result strobe
//   Div_data_valid  request strobe to the divider
//   Div_divident    unsigned dividend magnitude to the divider
//   Div_divisor     unsigned divisor magnitude to the divider
//   Div_out_valid   divider done strobe
//   Div_quotient    unsigned quotient from the divider
//   Div_remainder   unsigned remainder from the divider
// ---------------------------------------------------------------------------
module div_sequencer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Start,
    input  logic [1:0]            Op,
    input  logic [DATA_WIDTH-1:0] Op_a,
    input  logic [DATA_WIDTH-1:0] Op_b,
    input  logic                  Flush,
    output logic                  Busy,
    output logic [DATA_WIDTH-1:0] Result,
    output logic                  Result_valid,
    output logic                  Div_data_valid,
    output logic [DATA_WIDTH-1:0] Div_divident,
    output logic [DATA_WIDTH-1:0] Div_divisor,
    input  logic                  Div_out_valid,
    input  logic [DATA_WIDTH-1:0] Div_quotient,
    input  logic [DATA_WIDTH-1:0] Div_remainder
);

    localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] ALL_ZERO = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] ONE      = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] MIN_INT  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    // Two's-complement negation.
    function automatic logic [DATA_WIDTH-1:0] twos_neg(input logic [DATA_WIDTH-1:0] v);
        return ~v + ONE;
    endfunction

    // Negate v only when neg is set (used for both magnitude and sign fix-up).
    function automatic logic [DATA_WIDTH-1:0] cond_neg(input logic                  neg,
                                                       input logic [DATA_WIDTH-1:0] v);
        return neg ? twos_neg(v) : v;
    endfunction

    state_t                state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic                  neg_quo_q, neg_quo_d;
    logic                  neg_rem_q, neg_rem_d;
    logic [DATA_WIDTH-1:0] divident_q, divident_d;
    logic [DATA_WIDTH-1:0] divisor_q, divisor_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  result_valid_q, result_valid_d;
    logic                  div_data_valid_q, div_data_valid_d;
    logic                  busy_q, busy_d;

    // Request decode, evaluated on the incoming operands.
    logic                  is_signed;
    logic                  a_neg;
    logic                  b_neg;
    logic                  div_by_zero;
    logic                  sgn_overflow;
    logic                  special;
    logic [DATA_WIDTH-1:0] special_res;
    logic                  accept;
    logic [DATA_WIDTH-1:0] div_res;

    always_comb begin
        is_signed    = ~Op[0];
        a_neg        = is_signed & Op_a[DATA_WIDTH-1];
        b_neg        = is_signed & Op_b[DATA_WIDTH-1];
        div_by_zero  = (Op_b == ALL_ZERO);
        sgn_overflow = is_signed && (Op_a == MIN_INT) && (Op_b == ALL_ONES);
        special      = div_by_zero | sgn_overflow;

        // Divide-by-zero takes precedence; with b==0 the overflow pattern
        // cannot occur anyway.
        if (div_by_zero) begin
            special_res = Op[1] ? Op_a : ALL_ONES;
        end else begin
            special_res = Op[1] ? ALL_ZERO : MIN_INT;
        end

        // Flush beats a simultaneous Start; DONE accepts like IDLE so that
        // back-to-back operations lose no cycle.
        accept = ((state_q == IDLE) || (state_q == DONE)) && Start && !Flush;

        div_res = op_q[1] ? cond_neg(neg_rem_q, Div_remainder)
                          : cond_neg(neg_quo_q, Div_quotient);
    end

    always_comb begin
        state_d          = state_q;
        op_d             = op_q;
        neg_quo_d        = neg_quo_q;
        neg_rem_d        = neg_rem_q;
        divident_d       = divident_q;
        divisor_d        = divisor_q;
        result_d         = result_q;
        result_valid_d   = 1'b0;
        div_data_valid_d = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    op_d       = Op;
                    neg_quo_d  = a_neg ^ b_neg;
                    neg_rem_d  = a_neg;
                    divident_d = cond_neg(a_neg, Op_a);
                    divisor_d  = cond_neg(b_neg, Op_b);
                    if (special) begin
                        result_d       = special_res;
                        result_valid_d = 1'b1;
                        state_d        = DONE;
                    end else begin
                        div_data_valid_d = 1'b1;
                        state_d          = ISSUE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            ISSUE: begin
                // The request strobe is already out, so a flush here has to
                // wait for the divider to finish before the unit is reusable.
                state_d = Flush ? DRAIN : WAIT;
            end

            WAIT: begin
                if (Div_out_valid) begin
                    if (Flush) begin
                        state_d = IDLE;
                    end else begin
                        result_d       = div_res;
                        result_valid_d = 1'b1;
                        state_d        = DONE;
                    end
                end else if (Flush) begin
                    state_d = DRAIN;
                end
            end

            DRAIN: begin
                if (Div_out_valid) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == ISSUE) || (state_d == WAIT) || (state_d == DRAIN);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q          <= IDLE;
            op_q             <= 2'b00;
            neg_quo_q        <= 1'b0;
            neg_rem_q        <= 1'b0;
            divident_q       <= ALL_ZERO;
            divisor_q        <= ALL_ZERO;
            result_q         <= ALL_ZERO;
            result_valid_q   <= 1'b0;
            div_data_valid_q <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            op_q             <= op_d;
            neg_quo_q        <= neg_quo_d;
            neg_rem_q        <= neg_rem_d;
            divident_q       <= divident_d;
            divisor_q        <= divisor_d;
            result_q         <= result_d;
            result_valid_q   <= result_valid_d;
            div_data_valid_q <= div_data_valid_d;
            busy_q           <= busy_d;
        end
    end

    assign Busy           = busy_q;
    assign Result         = result_q;
    // A flush arriving in the DONE cycle must squash the strobe in that
    // same cycle, hence the only combinational term on an output.
    assign Result_valid   = result_valid_q & ~Flush;
    assign Div_data_valid = div_data_valid_q;
    assign Div_divident   = divident_q;
    assign Div_divisor    = divisor_q;

endmodule

// File: tb/tb_div_sequencer.sv
// ---------------------------------------------------------------------------
// tb_div_sequencer
//
// Bench for div_sequencer at DATA_WIDTH=8. It contains a behavioural divider
// whose latency is set per operation, and a scoreboard of expected results and
// expected divider requests.
// ---------------------------------------------------------------------------
module tb_div_sequencer;

    localparam int W = 8;

    logic         Clk = 1'b0;
    logic         Rst;
    logic         Start;
    logic [1:0]   Op;
    logic [W-1:0] Op_a;
    logic [W-1:0] Op_b;
    logic         Flush;
    logic         Busy;
    logic [W-1:0] Result;
    logic         Result_valid;
    logic         Div_data_valid;
    logic [W-1:0] Div_divident;
    logic [W-1:0] Div_divisor;
    logic         Div_out_valid = 1'b0;
    logic [W-1:0] Div_quotient  = '0;
    logic [W-1:0] Div_remainder = '0;

    div_sequencer #(.DATA_WIDTH(W)) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .Start          (Start),
        .Op             (Op),
        .Op_a           (Op_a),
        .Op_b           (Op_b),
        .Flush          (Flush),
        .Busy           (Busy),
        .Result         (Result),
        .Result_valid   (Result_valid),
        .Div_data_valid (Div_data_valid),
        .Div_divident   (Div_divident),
        .Div_divisor    (Div_divisor),
        .Div_out_valid  (Div_out_valid),
        .Div_quotient   (Div_quotient),
        .Div_remainder  (Div_remainder)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc = cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        int           cyc;
    } exp_t;

    exp_t           res_q[$];
    logic [2*W-1:0] dv_q[$];

    int n_vec = 0;
    int n_err = 0;
    int lat   = 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference semantics (RISC-V M extension).
    function automatic logic [W-1:0] ref_res(input logic [1:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        logic signed [W-1:0] sr;
        sa = a;
        sb = b;
        if (b == '0) return op[1] ? a : 8'hFF;
        if (!op[0] && a == 8'h80 && b == 8'hFF) return op[1] ? 8'h00 : 8'h80;
        if (!op[0]) begin
            sr = op[1] ? (sa % sb) : (sa / sb);
            return sr;
        end
        return op[1] ? (a % b) : (a / b);
    endfunction

    function automatic bit is_special(input logic [1:0] op, input logic [W-1:0] a,
                                      input logic [W-1:0] b);
        return (b == '0) || (!op[0] && a == 8'h80 && b == 8'hFF);
    endfunction

    function automatic logic [W-1:0] mag(input logic sgn, input logic [W-1:0] v);
        return (sgn && v[W-1]) ? (~v + 8'd1) : v;
    endfunction

    // Behavioural divider plus output monitor, both on the falling edge.
    int           cnt = 0;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    always @(negedge Clk) begin
        exp_t           e;
        logic [2*W-1:0] d;
        Div_out_valid = 1'b0;
        if (Rst) begin
            cnt = 0;
        end else if (Div_data_valid) begin
            cnt = lat;
            m_a = Div_divident;
            m_b = Div_divisor;
        end else if (cnt > 0) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
                Div_out_valid = 1'b1;
                Div_quotient  = (m_b == '0) ? 8'hFF : m_a / m_b;
                Div_remainder = (m_b == '0) ? m_a : m_a % m_b;
            end
        end

        if (Div_data_valid) begin
            if (dv_q.size() == 0) begin
                check_val("dv_spurious", 32'(Div_data_valid), 32'd0);
            end else begin
                d = dv_q.pop_front();
                check_val("div_divident", 32'(Div_divident), 32'(d[2*W-1:W]));
                check_val("div_divisor", 32'(Div_divisor), 32'(d[W-1:0]));
            end
        end

        if (Result_valid) begin
            if (res_q.size() == 0) begin
                check_val("rv_spurious", 32'(Result_valid), 32'd0);
            end else begin
                e = res_q.pop_front();
                check_val("result", 32'(Result), 32'(e.res));
                check_val("rv_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Drive a Start for the current cycle and record what must follow.
    task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int d, input bit exp_res, input logic [W-1:0] exp_val);
        exp_t e;
        bit   sp;
        lat   = d;
        Op    = op;
        Op_a  = a;
        Op_b  = b;
        Start = 1'b1;
        sp    = is_special(op, a, b);
        if (!Flush) begin
            if (!sp) dv_q.push_back({mag(!op[0], a), mag(!op[0], b)});
            if (exp_res) begin
                e.res = exp_val;
                e.cyc = cyc + (sp ? 1 : 2 + d);
                res_q.push_back(e);
            end
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (res_q.size() == 0 && !Busy) return;
            tick();
        end
        check_val("idle_timeout", 32'(Busy), 32'd0);
    endtask

    // Single operation with Busy profile checked cycle by cycle.
    task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int d, input logic [W-1:0] exp_val);
        bit sp;
        sp = is_special(op, a, b);
        launch(op, a, b, d, 1'b1, exp_val);
        tick();
        Start = 1'b0;
        for (int k = 1; k <= d + 3; k++) begin
            check_val("busy", 32'(Busy), 32'(!sp && k <= d + 1));
            tick();
        end
        wait_idle();
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_busy"}, 32'(Busy), 32'd0);
        check_val({tag, "_result"}, 32'(Result), 32'd0);
        check_val({tag, "_rv"}, 32'(Result_valid), 32'd0);
        check_val({tag, "_dv"}, 32'(Div_data_valid), 32'd0);
        check_val({tag, "_divident"}, 32'(Div_divident), 32'd0);
        check_val({tag, "_divisor"}, 32'(Div_divisor), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int           n;
        logic [1:0]   rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           rd;

        Rst   = 1'b1;
        Start = 1'b0;
        Flush = 1'b0;
        Op    = 2'b00;
        Op_a  = '0;
        Op_b  = '0;
        tick();
        tick();
        check_all_zero("reset");
        Rst = 1'b0;
        tick();
        check_all_zero("post_reset");

        // Basic and signed/unsigned normal-path cases.
        do_op(2'b00, 8'h48, 8'h18, 3, 8'h03);
        do_op(2'b00, 8'hF9, 8'hFD, 2, 8'h02);
        do_op(2'b10, 8'hF9, 8'hFD, 4, 8'hFF);
        do_op(2'b01, 8'hF9, 8'h03, 1, 8'h53);

        // Special cases: no divider involvement, result one cycle after Start.
        do_op(2'b01, 8'h25, 8'h00, 1, 8'hFF);
        do_op(2'b10, 8'h25, 8'h00, 1, 8'h25);
        do_op(2'b00, 8'h80, 8'hFF, 1, 8'h80);
        do_op(2'b10, 8'h80, 8'hFF, 1, 8'h00);

        // Result holds after its strobe.
        do_op(2'b00, 8'h48, 8'hFD, 2, 8'hE8);
        tick();
        tick();
        check_val("result_hold", 32'(Result), 32'h0000_00E8);

        // Flush in WAIT, Start during DRAIN ignored, no result.
        n = cyc;
        launch(2'b00, 8'h48, 8'h18, 6, 1'b0, 8'h00);
        tick();
        Start = 1'b0;
        tick();
        tick();
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        check_val("drain_busy", 32'(Busy), 32'd1);
        Op    = 2'b01;
        Op_a  = 8'h10;
        Op_b  = 8'h02;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check_val("drain_busy2", 32'(Busy), 32'd1);
        for (int i = 0; i < 30 && Busy; i++) tick();
        check_val("drain_exit_cycle", 32'(cyc), 32'(n + 8));
        tick();
        do_op(2'b01, 8'hC8, 8'h0A, 3, 8'h14);

        // Flush together with Start drops the request.
        Flush = 1'b1;
        launch(2'b00, 8'h30, 8'h05, 2, 1'b0, 8'h00);
        tick();
        Start = 1'b0;
        Flush = 1'b0;
        check_val("flush_start_busy", 32'(Busy), 32'd0);
        tick();
        check_val("flush_start_rv", 32'(Result_valid), 32'd0);

        // Flush in the DONE cycle squashes the strobe.
        launch(2'b01, 8'h25, 8'h00, 1, 1'b0, 8'h00);
        tick();
        Start = 1'b0;
        Flush = 1'b1;
        #1;
        check_val("flush_done_rv", 32'(Result_valid), 32'd0);
        tick();
        Flush = 1'b0;

        // Back-to-back: Start in the DONE cycle of the previous op.
        n = cyc;
        launch(2'b00, 8'hF9, 8'hFD, 2, 1'b1, 8'h02);
        tick();
        Start = 1'b0;
        tick();
        tick();
        tick();
        check_val("b2b_done_rv", 32'(Result_valid), 32'd1);
        launch(2'b10, 8'hF9, 8'hFD, 3, 1'b1, 8'hFF);
        tick();
        Start = 1'b0;
        check_val("b2b_dv", 32'(Div_data_valid), 32'd1);
        check_val("b2b_busy", 32'(Busy), 32'd1);
        wait_idle();

        // Reset in WAIT.
        launch(2'b00, 8'h48, 8'h18, 5, 1'b0, 8'h00);
        tick();
        Start = 1'b0;
        tick();
        tick();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        check_all_zero("rst_wait");
        for (int i = 0; i < 8; i++) tick();
        do_op(2'b11, 8'hF9, 8'h07, 2, 8'h04);

        // Randomised sweep against the reference model.
        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = 8'($urandom_range(0, 255));
            rb  = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 7))
                0: rb = 8'h00;
                1: begin ra = 8'h80; rb = 8'hFF; end
                2: ra = 8'h80;
                default: ;
            endcase
            rd = $urandom_range(1, 4);
            do_op(rop, ra, rb, rd, ref_res(rop, ra, rb));
        end

        tick();
        tick();
        check_val("res_q_left", 32'(res_q.size()), 32'd0);
        check_val("dv_q_left", 32'(dv_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
